// File: rtl/johnson_pkg.sv
// Shared definitions for the parametrised Johnson/ring counter.
//   MODE_JOHNSON / MODE_RING : build-time sequence selection
//   phase_width()            : width of the binary phase index
//   reset_pattern()          : power-up / recovery pattern for a mode
//   popcount32()             : number of set bits in a 32-bit word
package johnson_pkg;

    localparam int MODE_JOHNSON = 0;
    localparam int MODE_RING    = 1;

    // Phase index must cover 2*WIDTH Johnson states; ring mode uses a subset.
    function automatic int phase_width(input int width);
        return $clog2(2 * width);
    endfunction

    // Johnson starts from all-zero; ring needs exactly one token, placed at bit 0.
    function automatic logic [31:0] reset_pattern(input int mode);
        logic [31:0] pat;
        if (mode == MODE_RING) begin
            pat = 32'd1;
        end else begin
            pat = 32'd0;
        end
        return pat;
    endfunction

    function automatic logic [31:0] popcount32(input logic [31:0] v);
        logic [31:0] n;
        n = 32'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// Combinational legality check and phase decode of a counter state.
//   state : candidate counter value (WIDTH bits)
//   legal : 1 when state belongs to the sequence of the selected MODE
//   phase : binary index of state within the sequence (meaningful only when legal)
module johnson_phase_decode
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int MODE  = MODE_JOHNSON,
    localparam int PW    = phase_width(WIDTH)
) (
    input  logic [WIDTH-1:0] state,
    output logic             legal,
    output logic [PW-1:0]    phase
);

    logic [31:0] ones_s;

    assign ones_s = popcount32(32'(state));

    if (MODE == MODE_RING) begin : g_ring
        logic [31:0] idx_s;

        // For a one-hot word, OR-ing the indices of set bits yields the bit index.
        always_comb begin
            idx_s = 32'd0;
            for (int i = 0; i < WIDTH; i++) begin
                idx_s = idx_s | (state[i] ? 32'(i) : 32'd0);
            end
        end

        assign legal = (ones_s == 32'd1);
        assign phase = PW'(idx_s);
    end else begin : g_johnson
        localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
        logic [WIDTH-1:0] inv_s;
        logic             low_run_s;
        logic             high_run_s;

        // A run of ones anchored at bit 0 is a low mask (x & (x+1) == 0);
        // a run anchored at the MSB is a low mask of the inverted word.
        // Both forms include all-zero and all-one.
        assign inv_s      = ~state;
        assign low_run_s  = ((state & (state + ONE)) == {WIDTH{1'b0}});
        assign high_run_s = ((inv_s & (inv_s + ONE)) == {WIDTH{1'b0}});
        assign legal      = low_run_s | high_run_s;

        // First half of the sequence fills from bit 0; the second half
        // drains from bit 0 with the MSB still set.
        assign phase = state[WIDTH-1] ? PW'(32'(2 * WIDTH) - ones_s) : PW'(ones_s);
    end

endmodule

// File: rtl/johnson_counter_param.sv
// Parametrised Johnson (twisted ring) / ring (one-hot) sequence generator with
// enable, direction, checked synchronous load, self-correction, phase index and
// wrap pulse. All outputs are registered for glitch-free downstream decoding.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   en       : advance one state per clock
//   dir      : 0 = forward (toward MSB), 1 = reverse (toward LSB)
//   load     : synchronous load strobe (has priority over en)
//   load_val : value to load, rejected if not a legal state
//   count    : counter state
//   phase    : binary index of count within the sequence
//   wrap     : one-cycle pulse when a step crosses the sequence boundary
//   illegal  : one-cycle pulse on a rejected load or self-correction
// WIDTH legal range is 2..32.
module johnson_counter_param
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int MODE  = MODE_JOHNSON,
    localparam int PW    = phase_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             illegal
);

    localparam logic [31:0]      RST_FULL   = reset_pattern(MODE);
    localparam logic [WIDTH-1:0] RST_VAL    = RST_FULL[WIDTH-1:0];
    localparam logic [PW-1:0]    LAST_PHASE =
        PW'((MODE == MODE_RING) ? (WIDTH - 1) : (2 * WIDTH - 1));

    logic [WIDTH-1:0] count_r;
    logic [PW-1:0]    phase_r;
    logic             wrap_r;
    logic             illegal_r;

    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] cand_s;
    logic             legal_s;
    logic [PW-1:0]    phase_s;
    logic [WIDTH-1:0] count_nxt_s;
    logic [PW-1:0]    phase_nxt_s;
    logic             wrap_nxt_s;
    logic             illegal_nxt_s;

    // One step of the sequence in the direction sampled this cycle.
    always_comb begin
        step_s = count_r;
        if (MODE == MODE_RING) begin
            if (dir) begin
                step_s = {count_r[0], count_r[WIDTH-1:1]};
            end else begin
                step_s = {count_r[WIDTH-2:0], count_r[WIDTH-1]};
            end
        end else begin
            if (dir) begin
                step_s = {~count_r[0], count_r[WIDTH-1:1]};
            end else begin
                step_s = {count_r[WIDTH-2:0], ~count_r[WIDTH-1]};
            end
        end
    end

    // Candidate next state: load beats step beats hold.
    always_comb begin
        cand_s = count_r;
        if (load) begin
            cand_s = load_val;
        end else if (en) begin
            cand_s = step_s;
        end else begin
            cand_s = count_r;
        end
    end

    // Stepping maps legal states onto legal states and illegal onto illegal,
    // so checking the candidate covers both load checking and self-correction.
    johnson_phase_decode #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_decode (
        .state (cand_s),
        .legal (legal_s),
        .phase (phase_s)
    );

    // Next values for all registered outputs.
    always_comb begin
        count_nxt_s   = count_r;
        phase_nxt_s   = phase_r;
        wrap_nxt_s    = 1'b0;
        illegal_nxt_s = 1'b0;
        if (load || en) begin
            if (legal_s) begin
                count_nxt_s = cand_s;
                phase_nxt_s = phase_s;
                // A legal step lands on phase 0 going forward (or on the last
                // phase going backward) only when crossing the boundary.
                if (!load) begin
                    if (dir) begin
                        wrap_nxt_s = (phase_s == LAST_PHASE);
                    end else begin
                        wrap_nxt_s = (phase_s == {PW{1'b0}});
                    end
                end else begin
                    wrap_nxt_s = 1'b0;
                end
            end else begin
                count_nxt_s   = RST_VAL;
                phase_nxt_s   = {PW{1'b0}};
                illegal_nxt_s = 1'b1;
            end
        end else begin
            count_nxt_s = count_r;
            phase_nxt_s = phase_r;
        end
    end

    // State and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r   <= RST_VAL;
            phase_r   <= {PW{1'b0}};
            wrap_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            phase_r   <= phase_nxt_s;
            wrap_r    <= wrap_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    assign count   = count_r;
    assign phase   = phase_r;
    assign wrap    = wrap_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench for johnson_counter_param: a W=4 Johnson instance and a
// W=4 ring instance sharing one clock, each with its own stimulus.
module tb_johnson_counter_param;

    logic       clk;
    // Johnson instance
    logic       j_reset, j_en, j_dir, j_load;
    logic [3:0] j_load_val;
    logic [3:0] j_count;
    logic [2:0] j_phase;
    logic       j_wrap, j_illegal;
    // Ring instance
    logic       r_reset, r_en, r_dir, r_load;
    logic [3:0] r_load_val;
    logic [3:0] r_count;
    logic [2:0] r_phase;
    logic       r_wrap, r_illegal;

    int n_vec = 0;
    int n_err = 0;

    johnson_counter_param #(.WIDTH(4), .MODE(0)) dut_j (
        .clk(clk), .reset(j_reset), .en(j_en), .dir(j_dir), .load(j_load),
        .load_val(j_load_val), .count(j_count), .phase(j_phase),
        .wrap(j_wrap), .illegal(j_illegal)
    );

    johnson_counter_param #(.WIDTH(4), .MODE(1)) dut_r (
        .clk(clk), .reset(r_reset), .en(r_en), .dir(r_dir), .load(r_load),
        .load_val(r_load_val), .count(r_count), .phase(r_phase),
        .wrap(r_wrap), .illegal(r_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Let one rising edge happen and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_j(input string tag, input logic [3:0] c, input logic [2:0] p,
                           input logic w, input logic il);
        check_val({tag, ".count"},   32'(j_count),   32'(c));
        check_val({tag, ".phase"},   32'(j_phase),   32'(p));
        check_val({tag, ".wrap"},    32'(j_wrap),    32'(w));
        check_val({tag, ".illegal"}, 32'(j_illegal), 32'(il));
    endtask

    task automatic check_r(input string tag, input logic [3:0] c, input logic [2:0] p,
                           input logic w, input logic il);
        check_val({tag, ".count"},   32'(r_count),   32'(c));
        check_val({tag, ".phase"},   32'(r_phase),   32'(p));
        check_val({tag, ".wrap"},    32'(r_wrap),    32'(w));
        check_val({tag, ".illegal"}, 32'(r_illegal), 32'(il));
    endtask

    logic [3:0] fwd_cnt [8];
    logic [2:0] fwd_ph  [8];
    logic [3:0] ring_cnt [4];

    initial begin
        fwd_cnt  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        fwd_ph   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        ring_cnt = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        j_reset = 1'b0; j_en = 1'b0; j_dir = 1'b0; j_load = 1'b0; j_load_val = 4'b0000;
        r_reset = 1'b0; r_en = 1'b0; r_dir = 1'b0; r_load = 1'b0; r_load_val = 4'b0000;

        // ---------------- Johnson instance ----------------
        tick();
        check_j("j_reset", 4'b0000, 3'd0, 1'b0, 1'b0);

        j_reset = 1'b1;
        tick();
        check_j("j_idle_after_reset", 4'b0000, 3'd0, 1'b0, 1'b0);

        j_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_j($sformatf("j_fwd%0d", i), fwd_cnt[i], fwd_ph[i], (i == 7), 1'b0);
        end

        j_dir = 1'b1;
        tick();
        check_j("j_rev_wrap", 4'b1000, 3'd7, 1'b1, 1'b0);
        tick();
        check_j("j_rev_step", 4'b1100, 3'd6, 1'b0, 1'b0);

        j_dir = 1'b0; j_load = 1'b1; j_load_val = 4'b0111;
        tick();
        check_j("j_load_ok", 4'b0111, 3'd3, 1'b0, 1'b0);

        j_load_val = 4'b0101;
        tick();
        check_j("j_load_bad", 4'b0000, 3'd0, 1'b0, 1'b1);

        j_load = 1'b0; j_en = 1'b0;
        tick();
        check_j("j_flag_drop", 4'b0000, 3'd0, 1'b0, 1'b0);

        // Plant an illegal state directly in the counter register.
        force dut_j.count_r = 4'b1010;
        #1;
        release dut_j.count_r;
        tick();
        check_val("j_forced_hold.count",   32'(j_count),   32'(4'b1010));
        check_val("j_forced_hold.illegal", 32'(j_illegal), 32'(1'b0));

        j_en = 1'b1;
        tick();
        check_j("j_self_correct", 4'b0000, 3'd0, 1'b0, 1'b1);

        // ---------------- Ring instance ----------------
        check_r("r_reset", 4'b0001, 3'd0, 1'b0, 1'b0);
        r_reset = 1'b1;
        r_en    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_r($sformatf("r_fwd%0d", i), ring_cnt[i], 3'(i + 1 == 4 ? 0 : i + 1), (i == 3), 1'b0);
        end

        r_dir = 1'b1;
        tick();
        check_r("r_rev_wrap", 4'b1000, 3'd3, 1'b1, 1'b0);

        r_dir = 1'b0;
        tick();
        tick();
        check_r("r_mid", 4'b0010, 3'd1, 1'b0, 1'b0);

        // Asynchronous reset between edges must act without a clock edge.
        #2;
        r_reset = 1'b0;
        #1;
        check_r("r_async_reset", 4'b0001, 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
